// File: rtl/vote_entry_ctrl.sv
// Voter-facing entry controller: keypad/Correct/Blank/Confirm handling with a per-session lock,
// idle timeout and a single registered vote beat to the tally stage.
module vote_entry_ctrl #(
  parameter logic [3:0] CAND1          = 4'd1,
  parameter logic [3:0] CAND2          = 4'd5,
  parameter logic [3:0] CAND3          = 4'd6,
  parameter logic [3:0] CAND4          = 4'd8,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] KeyCode,
  input  logic       KeyStrobe,
  input  logic       Correct,
  input  logic       Blank,
  input  logic       Confirm,
  input  logic       Enable,
  input  logic       Close,
  output logic [3:0] Digit,
  output logic       Valid,
  output logic       VoteStrobe,
  output logic       Finish,
  output logic       Ready,
  output logic [3:0] Shown,
  output logic       Timeout,
  output logic [7:0] VoteCount
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {LOCKED, EMPTY, ENTERED, COMMIT, CLOSED} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    held_reg, held_next;
  logic [IW-1:0] idle_reg, idle_next;
  logic          timeout_next;
  logic          in_commit;
  logic          is_cand;

  assign in_commit = (state_reg == COMMIT);
  // A blank commit holds code 0, which is never a candidate code.
  assign is_cand = (held_reg == CAND1) || (held_reg == CAND2) ||
                   (held_reg == CAND3) || (held_reg == CAND4);

  always_comb begin
    state_next   = state_reg;
    held_next    = held_reg;
    idle_next    = idle_reg;
    timeout_next = 1'b0;
    case (state_reg)
      LOCKED: begin
        if (Close) begin
          state_next = CLOSED;
        end else if (Enable) begin
          state_next = EMPTY;
          held_next  = 4'd0;
          idle_next  = '0;
        end
      end
      EMPTY, ENTERED: begin
        // Events that are ignored in EMPTY (Correct, Confirm) do not mask lower-priority ones.
        if (Close) begin
          state_next = CLOSED;
          held_next  = 4'd0;
        end else if (state_reg == ENTERED && Correct) begin
          state_next = EMPTY;
          held_next  = 4'd0;
          idle_next  = '0;
        end else if (Blank) begin
          state_next = COMMIT;
          held_next  = 4'd0;
        end else if (state_reg == ENTERED && Confirm) begin
          state_next = COMMIT;
        end else if (KeyStrobe) begin
          state_next = ENTERED;
          held_next  = KeyCode;
          idle_next  = '0;
        end else if (idle_reg == IW'(TIMEOUT_CYCLES - 1)) begin
          state_next   = LOCKED;
          held_next    = 4'd0;
          timeout_next = 1'b1;
        end else begin
          idle_next = idle_reg + IW'(1);
        end
      end
      COMMIT: begin
        state_next = Close ? CLOSED : LOCKED;
        held_next  = 4'd0;
        idle_next  = '0;
      end
      CLOSED: state_next = CLOSED;
      default: state_next = LOCKED;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg  <= LOCKED;
      held_reg   <= 4'd0;
      idle_reg   <= '0;
      Digit      <= 4'd0;
      Valid      <= 1'b0;
      VoteStrobe <= 1'b0;
      Finish     <= 1'b0;
      Ready      <= 1'b0;
      Shown      <= 4'd0;
      Timeout    <= 1'b0;
      VoteCount  <= 8'd0;
    end else begin
      state_reg  <= state_next;
      held_reg   <= held_next;
      idle_reg   <= idle_next;
      // The vote beat is issued on the edge that leaves COMMIT.
      VoteStrobe <= in_commit;
      Digit      <= in_commit ? held_reg : 4'd0;
      Valid      <= in_commit && is_cand;
      if (in_commit && VoteCount != 8'hFF) begin
        VoteCount <= VoteCount + 8'd1;
      end
      Finish     <= Finish | (state_next == CLOSED);
      Ready      <= (state_next == EMPTY) || (state_next == ENTERED);
      Shown      <= (state_next == ENTERED) ? held_next : 4'd0;
      Timeout    <= timeout_next;
    end
  end

endmodule

// File: tb/tb_vote_entry_ctrl.sv
// Directed bench for vote_entry_ctrl: one task per scenario with inline expected-value checks.
module tb_vote_entry_ctrl;

  localparam int TO = 1000;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] KeyCode = 4'd0;
  logic       KeyStrobe = 1'b0, Correct = 1'b0, Blank = 1'b0, Confirm = 1'b0;
  logic       Enable = 1'b0, Close = 1'b0;
  logic [3:0] Digit, Shown;
  logic       Valid, VoteStrobe, Finish, Ready, Timeout;
  logic [7:0] VoteCount;

  int total = 0;
  int bad = 0;

  vote_entry_ctrl dut (
    .Clock(Clock), .Reset(Reset), .KeyCode(KeyCode), .KeyStrobe(KeyStrobe),
    .Correct(Correct), .Blank(Blank), .Confirm(Confirm), .Enable(Enable), .Close(Close),
    .Digit(Digit), .Valid(Valid), .VoteStrobe(VoteStrobe), .Finish(Finish),
    .Ready(Ready), .Shown(Shown), .Timeout(Timeout), .VoteCount(VoteCount)
  );

  always #5 Clock = ~Clock;

  // Advance one rising edge, then settle 1 ns so inputs change and outputs are sampled off-edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_enable();
    Enable = 1'b1; tick(); Enable = 1'b0;
  endtask

  task automatic do_key(input logic [3:0] k);
    KeyCode = k; KeyStrobe = 1'b1; tick(); KeyStrobe = 1'b0;
  endtask

  task automatic do_confirm();
    Confirm = 1'b1; tick(); Confirm = 1'b0;
  endtask

  task automatic do_blank();
    Blank = 1'b1; tick(); Blank = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1; tick(); tick(); Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({Digit, Valid, VoteStrobe, Finish, Ready, Shown, Timeout, VoteCount} !== 21'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {Digit, Valid, VoteStrobe, Finish, Ready, Shown, Timeout, VoteCount});
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_valid_vote();
    do_enable();
    total++;
    if (Ready !== 1'b1) begin bad++; $display("FAIL enable_ready: got %b want 1", Ready); end
    do_key(4'd5);
    total++;
    if (Shown !== 4'd5) begin bad++; $display("FAIL key_shown: got %0d want 5", Shown); end
    do_confirm();
    total++;
    if (VoteStrobe !== 1'b0) begin bad++; $display("FAIL commit_latency: strobe got %b want 0", VoteStrobe); end
    tick();
    total++;
    if ({VoteStrobe, Digit, Valid, VoteCount} !== {1'b1, 4'd5, 1'b1, 8'd1}) begin
      bad++;
      $display("FAIL vote5: strobe=%b digit=%0d valid=%b count=%0d want 1/5/1/1",
               VoteStrobe, Digit, Valid, VoteCount);
    end
    tick();
    total++;
    if ({VoteStrobe, Digit, Ready} !== 6'd0) begin
      bad++;
      $display("FAIL after_vote: strobe=%b digit=%0d ready=%b want 0/0/0", VoteStrobe, Digit, Ready);
    end
    $display("valid_vote: digit 5 cast, count=%0d", VoteCount);
  endtask

  task automatic test_nulo_blank();
    do_enable(); do_key(4'd3); do_confirm(); tick();
    total++;
    if ({VoteStrobe, Digit, Valid} !== {1'b1, 4'd3, 1'b0}) begin
      bad++;
      $display("FAIL nulo: strobe=%b digit=%0d valid=%b want 1/3/0", VoteStrobe, Digit, Valid);
    end
    tick();
    do_enable(); do_key(4'd7);
    Correct = 1'b1; tick(); Correct = 1'b0;
    total++;
    if ({Shown, Ready} !== {4'd0, 1'b1}) begin
      bad++;
      $display("FAIL correct: shown=%0d ready=%b want 0/1", Shown, Ready);
    end
    do_blank(); tick();
    total++;
    if ({VoteStrobe, Digit, Valid, VoteCount} !== {1'b1, 4'd0, 1'b0, 8'd3}) begin
      bad++;
      $display("FAIL blank: strobe=%b digit=%0d valid=%b count=%0d want 1/0/0/3",
               VoteStrobe, Digit, Valid, VoteCount);
    end
    tick();
    $display("nulo_blank: nulo and blank cast, count=%0d", VoteCount);
  endtask

  task automatic test_last_key_priority();
    do_enable(); do_key(4'd1); do_key(4'd8); do_confirm(); tick();
    total++;
    if ({VoteStrobe, Digit, Valid} !== {1'b1, 4'd8, 1'b1}) begin
      bad++;
      $display("FAIL last_key: strobe=%b digit=%0d valid=%b want 1/8/1", VoteStrobe, Digit, Valid);
    end
    tick();
    do_enable(); do_key(4'd6);
    Correct = 1'b1; Confirm = 1'b1; tick(); Correct = 1'b0; Confirm = 1'b0;
    tick();
    total++;
    if ({VoteStrobe, Ready, Shown} !== {1'b0, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL correct_over_confirm: strobe=%b ready=%b shown=%0d want 0/1/0",
               VoteStrobe, Ready, Shown);
    end
    do_blank(); tick(); tick();
    total++;
    if (VoteCount !== 8'd5) begin bad++; $display("FAIL count5: got %0d want 5", VoteCount); end
    $display("last_key_priority: count=%0d", VoteCount);
  endtask

  task automatic test_timeout();
    do_enable();
    repeat (TO - 1) tick();
    total++;
    if ({Ready, Timeout} !== 2'b10) begin
      bad++;
      $display("FAIL pre_timeout: ready=%b timeout=%b want 1/0", Ready, Timeout);
    end
    tick();
    total++;
    if ({Timeout, Ready, VoteStrobe} !== 3'b100) begin
      bad++;
      $display("FAIL timeout: timeout=%b ready=%b strobe=%b want 1/0/0", Timeout, Ready, VoteStrobe);
    end
    tick();
    total++;
    if (Timeout !== 1'b0) begin bad++; $display("FAIL timeout_pulse: got %b want 0", Timeout); end
    do_confirm(); tick();
    total++;
    if ({VoteStrobe, VoteCount} !== {1'b0, 8'd5}) begin
      bad++;
      $display("FAIL locked_confirm: strobe=%b count=%0d want 0/5", VoteStrobe, VoteCount);
    end
    $display("timeout: session abandoned after %0d idle cycles", TO);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 251; i++) begin
      do_enable(); do_key(4'd1); do_confirm(); tick(); tick();
    end
    total++;
    if (VoteCount !== 8'd255) begin bad++; $display("FAIL saturate: got %0d want 255", VoteCount); end
    $display("saturation: count=%0d after 256 votes", VoteCount);
  endtask

  task automatic test_close_entered();
    do_enable(); do_key(4'd5);
    Close = 1'b1; tick(); Close = 1'b0;
    total++;
    if ({Finish, Ready, Shown} !== {1'b1, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL close_entered: finish=%b ready=%b shown=%0d want 1/0/0", Finish, Ready, Shown);
    end
    do_confirm(); do_enable(); tick();
    total++;
    if ({VoteStrobe, Ready, Finish, VoteCount} !== {1'b0, 1'b0, 1'b1, 8'd255}) begin
      bad++;
      $display("FAIL closed_ignores: strobe=%b ready=%b finish=%b count=%0d want 0/0/1/255",
               VoteStrobe, Ready, Finish, VoteCount);
    end
    $display("close_entered: finish=%b, no vote", Finish);
  endtask

  task automatic test_close_commit();
    do_reset();
    do_enable(); do_key(4'd6); do_confirm();
    Close = 1'b1; tick(); Close = 1'b0;
    total++;
    if ({VoteStrobe, Digit, Valid, VoteCount} !== {1'b1, 4'd6, 1'b1, 8'd1}) begin
      bad++;
      $display("FAIL close_commit_vote: strobe=%b digit=%0d valid=%b count=%0d want 1/6/1/1",
               VoteStrobe, Digit, Valid, VoteCount);
    end
    tick();
    total++;
    if ({Finish, Ready, VoteStrobe} !== 3'b100) begin
      bad++;
      $display("FAIL close_commit_finish: finish=%b ready=%b strobe=%b want 1/0/0",
               Finish, Ready, VoteStrobe);
    end
    $display("close_commit: vote counted then finish=%b", Finish);
  endtask

  task automatic test_reset_mid_entry();
    do_reset();
    do_enable(); do_key(4'd6);
    Reset = 1'b1; tick(); Reset = 1'b0;
    total++;
    if ({Digit, Valid, VoteStrobe, Finish, Ready, Shown, Timeout, VoteCount} !== 21'd0) begin
      bad++;
      $display("FAIL reset_mid: got %h want 0",
               {Digit, Valid, VoteStrobe, Finish, Ready, Shown, Timeout, VoteCount});
    end
    do_enable();
    total++;
    if (Ready !== 1'b1) begin bad++; $display("FAIL reset_locked: ready=%b want 1", Ready); end
    $display("reset_mid_entry: back to locked");
  endtask

  initial begin
    test_reset();
    test_valid_vote();
    test_nulo_blank();
    test_last_key_priority();
    test_timeout();
    test_saturation();
    test_close_entered();
    test_close_commit();
    test_reset_mid_entry();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
